tank_bullet: RTL and testbench
==============================

Name: tank_bullet

Overview:
- Single-bullet projectile engine, one instance per tank.
- Sits directly downstream of the tank position/direction stage. Consumes tank central x/y and the 2-bit facing direction.
- On a fire request it spawns a bullet one cell ahead of the tank. It advances the bullet one cell every STEP_FRAMES frame ticks until the bullet leaves the map or the game reports a hit.
- Bullet position, direction and active flag go to Game (collision) and VGA (drawing).

Parameters:
- MAP_MAX, 39: largest legal x and y cell coordinate; legal range is 0..MAP_MAX.
- STEP_FRAMES, 2: frame ticks per one-cell bullet move; must be >= 1.
- COOLDOWN_FRAMES, 8: frame ticks of fire lockout after the bullet dies; used only with TANK_BULLET_COOLDOWN_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per game frame; same strobe as the tank stage's valid_take_direction
- fire  in  1  fire request, level; sampled every cycle
- tank_x  in  6  tank central x
- tank_y  in  6  tank central y
- tank_dir  in  2  tank facing: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT
- hit  in  1  Game collision result for the current bullet cell; meaningful only while bullet_active
- fire_ack  out  1  one-cycle pulse: request accepted, bullet spawned
- bullet_active  out  1  bullet exists and must be drawn and collided
- bullet_x  out  6  bullet cell x
- bullet_y  out  6  bullet cell y
- bullet_dir  out  2  bullet travel direction, same encoding as tank_dir

Behaviour:
- Clock/reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values:
  - state IDLE
  - bullet_active 0, fire_ack 0
  - bullet_x 0, bullet_y 0, bullet_dir 0
  - step counter 0, cooldown counter 0
  - Reset mid-flight kills the bullet immediately.
- States: IDLE, FLY, plus COOL (macro builds only).
- Spawn cell: tank cell plus one cell in tank_dir.
  - UP: y-1. DOWN: y+1. LEFT: x-1. RIGHT: x+1.
- IDLE:
  - If fire=1 and the spawn cell is in range, then on the next edge:
    - bullet_x/y take the spawn cell; bullet_dir takes tank_dir.
    - bullet_active goes to 1 and fire_ack pulses for one cycle.
    - Step counter clears; state goes to FLY.
  - Fire does not wait for frame_tick; latency is 1 cycle.
  - Out of range means y=0 for UP, y=MAP_MAX for DOWN, x=0 for LEFT, x=MAP_MAX for RIGHT. In that case the request is dropped: no ack, stay in IDLE.
  - hit is ignored in IDLE.
- FLY, evaluated in priority order:
  1. hit=1: bullet_active goes to 0 next edge; state goes to IDLE (COOL with macro). Position holds its last value. Hit takes priority over a simultaneous frame_tick.
  2. frame_tick=1 and step counter = STEP_FRAMES-1: counter clears.
     - If the next cell is in range, move one cell in bullet_dir.
     - Otherwise the bullet dies without moving, as for hit.
  3. frame_tick=1 otherwise: step counter increments.
  - fire is ignored in FLY: one bullet per tank, no ack.
  - tank_x, tank_y and tank_dir are ignored after spawn; the bullet does not follow the tank.
- Arithmetic: 6-bit unsigned; range checks are done before the +/-1, so wrap never occurs. Counter width is $clog2(STEP_FRAMES+1).
- fire held high: exactly one ack per bullet life. Re-fire is possible the cycle after entering IDLE.

Optional Feature:
- Macro: TANK_BULLET_COOLDOWN_EN.
- Defined:
  - Bullet death (hit or boundary) enters COOL and loads the cooldown counter with COOLDOWN_FRAMES.
  - Each frame_tick decrements the counter; at 0 the state returns to IDLE.
  - fire is ignored in COOL; bullet_active is 0.
- Undefined: the COOL state and counter are absent, and death goes straight to IDLE.

Decomposition:
- Shared package tank_pkg holds:
  - direction enum: UP=0, DOWN=1, LEFT=2, RIGHT=3, STAND=4. The 2-bit form is used for facing.
  - MAP_MAX default.
  - bullet state enum.
- The same package is reused by the tank stage and VGA.
- One natural sub-module: grid_step. It is combinational: (x, y, dir) gives (next_x, next_y, in_range). It is shared by spawn and move, and later by tank collision.

Test Plan:
- Spawn: tank (10,10), dir RIGHT, fire 1 cycle -> next cycle fire_ack=1, bullet_active=1, bullet (11,10), bullet_dir=3.
- Movement with STEP_FRAMES=2: 4 frame_ticks after the spawn above -> bullet (13,10). Non-tick cycles cause no change.
- Boundary: tank (38,5) RIGHT, spawn at (39,5); next move point -> bullet_active=0, x stays 39. Tank (0,5) LEFT fire -> no ack, stays inactive.
- Hit priority: bullet active, hit=1 and move-point frame_tick in the same cycle -> inactive next cycle, position unchanged. An immediate re-fire with fire held -> exactly one new ack.
- Fire while flying: fire pulses during FLY -> no ack, bullet path unaffected. Async rst_n low mid-flight -> all outputs 0 without a clock edge.
- With TANK_BULLET_COOLDOWN_EN, COOLDOWN_FRAMES=8: after the bullet dies, fire held -> ack only after the 8th frame_tick plus one cycle.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared tank game package: direction encoding, map size and bullet FSM states.
// Used by the tank position stage, the bullet engine and the VGA renderer.
package tank_pkg;

    // Largest legal cell coordinate on either axis (legal range 0..MAP_MAX_DEF)
    localparam int MAP_MAX_DEF = 39;
    localparam int COORD_W     = 6;

    // Full direction set; STAND is only meaningful for tank motion
    typedef enum logic [2:0] {
        DIR_UP    = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_STAND = 3'd4
    } dir_e;

    // 2-bit facing form (UP/DOWN/LEFT/RIGHT only)
    typedef logic [1:0] dir2_t;

    localparam dir2_t D2_UP    = 2'd0;
    localparam dir2_t D2_DOWN  = 2'd1;
    localparam dir2_t D2_LEFT  = 2'd2;
    localparam dir2_t D2_RIGHT = 2'd3;

    // Bullet engine states; BS_COOL is reachable only in cooldown builds
    typedef enum logic [1:0] {
        BS_IDLE = 2'd0,
        BS_FLY  = 2'd1,
        BS_COOL = 2'd2
    } bullet_state_e;

endpackage

// File: rtl/grid_step.sv
// One-cell grid step: given a cell and a facing, returns the neighbour cell
// and whether it lies on the map. The range check happens before the +/-1 so
// the 6-bit coordinates never wrap; when out of range the input cell is echoed.
module grid_step
    import tank_pkg::*;
#(
    parameter int MAP_MAX = MAP_MAX_DEF
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  dir2_t              dir,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               in_range
);

    localparam logic [COORD_W-1:0] EDGE = COORD_W'(MAP_MAX);

    // Neighbour cell in the facing direction, guarded against the map edge
    always_comb begin
        next_x   = x;
        next_y   = y;
        in_range = 1'b0;
        case (dir)
            D2_UP: begin
                in_range = (y != '0);
                if (in_range) next_y = y - 1'b1;
            end
            D2_DOWN: begin
                in_range = (y < EDGE);
                if (in_range) next_y = y + 1'b1;
            end
            D2_LEFT: begin
                in_range = (x != '0);
                if (in_range) next_x = x - 1'b1;
            end
            default: begin
                in_range = (x < EDGE);
                if (in_range) next_x = x + 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/tank_bullet.sv
// Single-bullet projectile engine, one per tank.
// Spawns a bullet one cell ahead of the tank on fire, advances it one cell
// every STEP_FRAMES frame ticks, and kills it on hit or at the map edge.
// Optional build macro TANK_BULLET_COOLDOWN_EN adds a COOL state that locks
// out firing for COOLDOWN_FRAMES frame ticks after each bullet death.
module tank_bullet
    import tank_pkg::*;
#(
    parameter int MAP_MAX         = MAP_MAX_DEF,
    parameter int STEP_FRAMES     = 2,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               fire,
    input  logic [COORD_W-1:0] tank_x,
    input  logic [COORD_W-1:0] tank_y,
    input  dir2_t              tank_dir,
    input  logic               hit,
    output logic               fire_ack,
    output logic               bullet_active,
    output logic [COORD_W-1:0] bullet_x,
    output logic [COORD_W-1:0] bullet_y,
    output dir2_t              bullet_dir
);

    localparam int             STEP_W    = $clog2(STEP_FRAMES + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_FRAMES - 1);

    if (STEP_FRAMES < 1 || COOLDOWN_FRAMES < 1) begin : g_param_check
        $error("tank_bullet: STEP_FRAMES and COOLDOWN_FRAMES must be >= 1");
    end

    bullet_state_e      state, state_nxt;
    logic [STEP_W-1:0]  step_cnt;
    logic               do_spawn, do_move, do_die, step_clr, step_inc;

    logic [COORD_W-1:0] spawn_x, spawn_y, move_x, move_y;
    logic               spawn_ok, move_ok;

    // Spawn cell is the tank cell stepped once in the facing direction
    grid_step #(.MAP_MAX(MAP_MAX)) u_spawn_step (
        .x        (tank_x),
        .y        (tank_y),
        .dir      (tank_dir),
        .next_x   (spawn_x),
        .next_y   (spawn_y),
        .in_range (spawn_ok)
    );

    // Next flight cell is the bullet cell stepped once in its travel direction
    grid_step #(.MAP_MAX(MAP_MAX)) u_move_step (
        .x        (bullet_x),
        .y        (bullet_y),
        .dir      (bullet_dir),
        .next_x   (move_x),
        .next_y   (move_y),
        .in_range (move_ok)
    );

`ifdef TANK_BULLET_COOLDOWN_EN
    localparam int                COOL_W    = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_FRAMES);
    logic [COOL_W-1:0] cool_cnt;

    // Cooldown counter: loaded on death, counts frame ticks down while cooling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cool_cnt <= '0;
        end else if (do_die) begin
            cool_cnt <= COOL_LOAD;
        end else if (state == BS_COOL && frame_tick && cool_cnt != '0) begin
            cool_cnt <= cool_cnt - 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BS_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and datapath strobes; hit outranks a simultaneous frame tick
    always_comb begin
        state_nxt = state;
        do_spawn  = 1'b0;
        do_move   = 1'b0;
        do_die    = 1'b0;
        step_clr  = 1'b0;
        step_inc  = 1'b0;
        case (state)
            BS_IDLE: begin
                if (fire && spawn_ok) begin
                    do_spawn  = 1'b1;
                    state_nxt = BS_FLY;
                end
            end
            BS_FLY: begin
                if (hit) begin
                    do_die = 1'b1;
                end else if (frame_tick) begin
                    if (step_cnt == STEP_LAST) begin
                        step_clr = 1'b1;
                        if (move_ok) do_move = 1'b1;
                        else         do_die  = 1'b1;
                    end else begin
                        step_inc = 1'b1;
                    end
                end
                if (do_die) begin
`ifdef TANK_BULLET_COOLDOWN_EN
                    state_nxt = BS_COOL;
`else
                    state_nxt = BS_IDLE;
`endif
                end
            end
`ifdef TANK_BULLET_COOLDOWN_EN
            BS_COOL: begin
                // Leave on the tick that takes the counter to zero
                if (frame_tick && cool_cnt <= 1) state_nxt = BS_IDLE;
            end
`endif
            default: state_nxt = BS_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bullet_active = (state == BS_FLY);
    end

    // Bullet position, direction, step counter and accept pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_ack   <= 1'b0;
            bullet_x   <= '0;
            bullet_y   <= '0;
            bullet_dir <= D2_UP;
            step_cnt   <= '0;
        end else begin
            fire_ack <= do_spawn;
            if (do_spawn) begin
                bullet_x   <= spawn_x;
                bullet_y   <= spawn_y;
                bullet_dir <= tank_dir;
            end else if (do_move) begin
                bullet_x <= move_x;
                bullet_y <= move_y;
            end
            if (do_spawn || step_clr) step_cnt <= '0;
            else if (step_inc)        step_cnt <= step_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tank_bullet.sv
// Self-checking bench for tank_bullet (default build, no cooldown).
// A cycle-level reference model tracks the bullet with plain integer
// arithmetic; scenario tasks also check hand-derived constants.
module tb_tank_bullet;

    localparam int MAP_MAX     = 39;
    localparam int STEP_FRAMES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, fire, hit;
    logic [5:0] tank_x, tank_y;
    logic [1:0] tank_dir;
    logic       fire_ack, bullet_active;
    logic [5:0] bullet_x, bullet_y;
    logic [1:0] bullet_dir;

    int tests_run = 0;
    int failed    = 0;

    // Reference model state
    bit m_active, m_ack;
    int m_x, m_y, m_dir, m_ticks;

    tank_bullet #(
        .MAP_MAX        (MAP_MAX),
        .STEP_FRAMES    (STEP_FRAMES),
        .COOLDOWN_FRAMES(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .fire         (fire),
        .tank_x       (tank_x),
        .tank_y       (tank_y),
        .tank_dir     (tank_dir),
        .hit          (hit),
        .fire_ack     (fire_ack),
        .bullet_active(bullet_active),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_dir   (bullet_dir)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 0; m_ack = 0; m_x = 0; m_y = 0; m_dir = 0; m_ticks = 0;
    endtask

    task automatic model_cell(input int x, input int y, input int d,
                              output int nx, output int ny, output bit ok);
        nx = x; ny = y;
        case (d)
            0: ny = y - 1;
            1: ny = y + 1;
            2: nx = x - 1;
            default: nx = x + 1;
        endcase
        ok = (nx >= 0) && (nx <= MAP_MAX) && (ny >= 0) && (ny <= MAP_MAX);
    endtask

    // Advance the model on the current inputs, then clock the DUT once
    task automatic step_clk();
        int nx, ny;
        bit ok;
        m_ack = 0;
        if (!m_active) begin
            if (fire) begin
                model_cell(int'(tank_x), int'(tank_y), int'(tank_dir), nx, ny, ok);
                if (ok) begin
                    m_active = 1; m_ack = 1; m_x = nx; m_y = ny;
                    m_dir = int'(tank_dir); m_ticks = 0;
                end
            end
        end else if (hit) begin
            m_active = 0;
        end else if (frame_tick) begin
            m_ticks++;
            if (m_ticks >= STEP_FRAMES) begin
                m_ticks = 0;
                model_cell(m_x, m_y, m_dir, nx, ny, ok);
                if (ok) begin m_x = nx; m_y = ny; end
                else m_active = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fire = 0; hit = 0; frame_tick = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs();
        tank_x = 0; tank_y = 0; tank_dir = 0;
        model_reset();
        #12;
        tests_run++;
        if ({bullet_active, fire_ack, bullet_x, bullet_y, bullet_dir} !== 15'd0) begin
            failed++;
            $display("FAIL reset_state: got act=%0b ack=%0b (%0d,%0d) dir=%0d, want all 0",
                     bullet_active, fire_ack, bullet_x, bullet_y, bullet_dir);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_spawn();
        tank_x = 10; tank_y = 10; tank_dir = 3; fire = 1;
        step_clk();
        fire = 0;
        tests_run++;
        if ({fire_ack, bullet_active, bullet_x, bullet_y, bullet_dir} !== {1'b1, 1'b1, 6'd11, 6'd10, 2'd3}) begin
            failed++;
            $display("FAIL spawn: got ack=%0b act=%0b (%0d,%0d) dir=%0d, want ack=1 act=1 (11,10) dir=3",
                     fire_ack, bullet_active, bullet_x, bullet_y, bullet_dir);
        end
        step_clk();
        tests_run++;
        if (fire_ack !== 1'b0) begin
            failed++;
            $display("FAIL spawn_ack_pulse: got ack=%0b, want 0", fire_ack);
        end
    endtask

    task automatic test_move();
        bit pat [7] = '{1, 0, 1, 0, 0, 1, 1};
        for (int i = 0; i < 7; i++) begin
            frame_tick = pat[i];
            step_clk();
            tests_run++;
            if (bullet_x !== 6'(m_x) || bullet_y !== 6'(m_y) || bullet_active !== m_active) begin
                failed++;
                $display("FAIL move_step%0d: got act=%0b (%0d,%0d), want act=%0b (%0d,%0d)",
                         i, bullet_active, bullet_x, bullet_y, m_active, m_x, m_y);
            end
        end
        frame_tick = 0;
        tests_run++;
        if ({bullet_x, bullet_y} !== {6'd13, 6'd10}) begin
            failed++;
            $display("FAIL move_4ticks: got (%0d,%0d), want (13,10)", bullet_x, bullet_y);
        end
        hit = 1;
        step_clk();
        hit = 0;
        tests_run++;
        if (bullet_active !== 1'b0) begin
            failed++;
            $display("FAIL move_hit_kill: got act=%0b, want 0", bullet_active);
        end
    endtask

    task automatic test_boundary();
        tank_x = 38; tank_y = 5; tank_dir = 3; fire = 1;
        step_clk();
        fire = 0;
        tests_run++;
        if ({fire_ack, bullet_active, bullet_x, bullet_y} !== {1'b1, 1'b1, 6'd39, 6'd5}) begin
            failed++;
            $display("FAIL edge_spawn: got ack=%0b act=%0b (%0d,%0d), want ack=1 act=1 (39,5)",
                     fire_ack, bullet_active, bullet_x, bullet_y);
        end
        frame_tick = 1;
        step_clk();
        step_clk();
        frame_tick = 0;
        tests_run++;
        if ({bullet_active, bullet_x, bullet_y} !== {1'b0, 6'd39, 6'd5}) begin
            failed++;
            $display("FAIL edge_die: got act=%0b (%0d,%0d), want act=0 (39,5)",
                     bullet_active, bullet_x, bullet_y);
        end
        tank_x = 0; tank_y = 5; tank_dir = 2; fire = 1;
        step_clk();
        fire = 0;
        tests_run++;
        if ({fire_ack, bullet_active} !== 2'b00) begin
            failed++;
            $display("FAIL edge_drop: got ack=%0b act=%0b, want ack=0 act=0", fire_ack, bullet_active);
        end
    endtask

    task automatic test_hit_priority();
        int acks = 0;
        tank_x = 20; tank_y = 20; tank_dir = 0; fire = 1;
        step_clk();
        fire = 0;
        frame_tick = 1;
        step_clk();
        hit = 1;
        step_clk();
        hit = 0; frame_tick = 0;
        tests_run++;
        if ({bullet_active, bullet_x, bullet_y} !== {1'b0, 6'd20, 6'd19}) begin
            failed++;
            $display("FAIL hit_priority: got act=%0b (%0d,%0d), want act=0 (20,19)",
                     bullet_active, bullet_x, bullet_y);
        end
        fire = 1;
        for (int i = 0; i < 6; i++) begin
            frame_tick = i[0];
            step_clk();
            if (fire_ack) acks++;
        end
        fire = 0; frame_tick = 0;
        tests_run++;
        if (acks != 1) begin
            failed++;
            $display("FAIL refire_held: got %0d acks, want 1", acks);
        end
        hit = 1;
        step_clk();
        hit = 0;
    endtask

    task automatic test_fire_in_flight();
        tank_x = 5; tank_y = 30; tank_dir = 1; fire = 1;
        step_clk();
        for (int i = 0; i < 8; i++) begin
            fire = 1'($urandom);
            frame_tick = i[0];
            tank_x = 6'($urandom_range(0, 39));
            tank_dir = 2'($urandom);
            step_clk();
            tests_run++;
            if (fire_ack !== 1'b0 || bullet_y !== 6'(m_y) || bullet_x !== 6'(m_x)) begin
                failed++;
                $display("FAIL fly_fire%0d: got ack=%0b (%0d,%0d), want ack=0 (%0d,%0d)",
                         i, fire_ack, bullet_x, bullet_y, m_x, m_y);
            end
        end
        idle_inputs();
        tests_run++;
        if ({bullet_active, bullet_x, bullet_y, bullet_dir} !== {1'b1, 6'd5, 6'd33, 2'd1}) begin
            failed++;
            $display("FAIL fly_path: got act=%0b (%0d,%0d) dir=%0d, want act=1 (5,33) dir=1",
                     bullet_active, bullet_x, bullet_y, bullet_dir);
        end
    endtask

    task automatic test_random();
        int pick;
        for (int i = 0; i < 400; i++) begin
            fire       = ($urandom_range(0, 99) < 30);
            frame_tick = ($urandom_range(0, 99) < 40);
            hit        = ($urandom_range(0, 99) < 8);
            pick = $urandom_range(0, 4);
            tank_x = (pick == 0) ? 6'd0 : (pick == 1) ? 6'd39 : (pick == 2) ? 6'd1 : 6'($urandom_range(0, 39));
            pick = $urandom_range(0, 4);
            tank_y = (pick == 0) ? 6'd0 : (pick == 1) ? 6'd39 : (pick == 2) ? 6'd38 : 6'($urandom_range(0, 39));
            tank_dir = 2'($urandom);
            step_clk();
            tests_run++;
            if ({bullet_active, fire_ack, bullet_x, bullet_y, bullet_dir} !==
                {m_active, m_ack, 6'(m_x), 6'(m_y), 2'(m_dir)}) begin
                failed++;
                $display("FAIL rand_cyc%0d: got act=%0b ack=%0b (%0d,%0d) dir=%0d, want act=%0b ack=%0b (%0d,%0d) dir=%0d",
                         i, bullet_active, fire_ack, bullet_x, bullet_y, bullet_dir,
                         m_active, m_ack, m_x, m_y, m_dir);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        hit = 1;
        step_clk();
        hit = 0;
        tank_x = 15; tank_y = 15; tank_dir = 3; fire = 1;
        step_clk();
        fire = 0;
        tests_run++;
        if (bullet_active !== 1'b1) begin
            failed++;
            $display("FAIL arst_setup: got act=%0b, want 1", bullet_active);
        end
        #2;
        rst_n = 0;
        #1;
        model_reset();
        tests_run++;
        if ({bullet_active, fire_ack, bullet_x, bullet_y, bullet_dir} !== 15'd0) begin
            failed++;
            $display("FAIL arst_midflight: got act=%0b ack=%0b (%0d,%0d) dir=%0d, want all 0",
                     bullet_active, fire_ack, bullet_x, bullet_y, bullet_dir);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_move();
        test_boundary();
        test_hit_priority();
        test_fire_in_flight();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
